// File: rtl/sram_dual_port_sched_pkg.sv
// Shared types and constants for the dual-requester SRAM sequencer.
// Legal WAIT_CYC range is 0..WAIT_MAX; the strobe counter is sized to match.
package sram_dual_port_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic        PH_LO    = 1'b0;
  localparam logic        PH_HI    = 1'b1;
  localparam int unsigned WAIT_MAX = 15;
  localparam int          CNT_W    = 4;

  // Active-low lane strobes {nUB, nLB}: reads always open both lanes.
  function automatic logic [1:0] lane_n(input logic we, input logic [3:0] be, input logic ph);
    if (!we) return 2'b00;
    return (ph == PH_HI) ? ~be[3:2] : ~be[1:0];
  endfunction

endpackage

// File: rtl/sram_dual_port_sched_arb.sv
// Two-port round-robin arbiter; combinational one-hot grant, pointer updates on upd_i.
// Reset leaves port 1 as last winner so port 0 takes the first tie.
module sram_dual_port_sched_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i && (|gnt_o)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/sram_dual_port_sched.sv
// Arbitrates two 32-bit requesters onto a 16-bit async SRAM, two halfword phases per word.
// ACK in cycle 1+2*(WAIT_CYC+3) after IDLE sample; requesters hold REQ until ACK.
module sram_dual_port_sched
  import sram_dual_port_sched_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned AW       = 19
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-2:0] ADDR0,
  input  logic [AW-2:0] ADDR1,
  input  logic [31:0]   WDATA0,
  input  logic [31:0]   WDATA1,
  input  logic [3:0]    BE0,
  input  logic [3:0]    BE1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [31:0]   RDATA,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [15:0]   SRAM_DQ_O,
  output logic          SRAM_DQ_OE,
  input  logic [15:0]   SRAM_DQ_I,
  output logic          SRAM_nCE,
  output logic          SRAM_nWE,
  output logic          SRAM_nOE,
  output logic          SRAM_nLB,
  output logic          SRAM_nUB
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [AW-2:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [1:0]       arb_gnt;
  logic             arb_upd;
  logic             active;
  logic             strobe;
  logic [1:0]       lanes_n;

  sram_dual_port_sched_arb u_arb (
    .clk_i (HCLK),
    .rst_i (HRESET),
    .req_i ({REQ1, REQ0}),
    .upd_i (arb_upd),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    arb_upd = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          arb_upd = 1'b1;
          gnt_d   = arb_gnt[1];
          we_d    = arb_gnt[1] ? WE1    : WE0;
          addr_d  = arb_gnt[1] ? ADDR1  : ADDR0;
          wdata_d = arb_gnt[1] ? WDATA1 : WDATA0;
          be_d    = arb_gnt[1] ? BE1    : BE0;
          phase_d = PH_LO;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = WAIT_LD;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          // Sample the pad on the last strobe cycle, the latest point data is guaranteed valid.
          if (!we_q) begin
            if (phase_q == PH_HI) rdata_d[31:16] = SRAM_DQ_I;
            else                  rdata_d[15:0]  = SRAM_DQ_I;
          end
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q == PH_LO) begin
          phase_d = PH_HI;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      phase_q <= PH_LO;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset releases the pins immediately.
  assign active  = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign strobe  = (state_q == ST_STROBE);
  assign lanes_n = active ? lane_n(we_q, be_q, phase_q) : 2'b11;

  assign SRAM_nCE   = ~active;
  assign SRAM_nWE   = ~(strobe && we_q);
  assign SRAM_nOE   = ~(strobe && !we_q);
  assign SRAM_nUB   = lanes_n[1];
  assign SRAM_nLB   = lanes_n[0];
  assign SRAM_DQ_OE = active && we_q;
  assign SRAM_DQ_O  = (phase_q == PH_HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_ADDR  = {addr_q, phase_q};

  assign ACK0  = (state_q == ST_DONE) && !gnt_q;
  assign ACK1  = (state_q == ST_DONE) &&  gnt_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_sram_dual_port_sched.sv
// Directed + randomized bench: SRAM pin model plus word-level reference memory.
module tb_sram_dual_port_sched;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        REQ0, REQ1, WE0, WE1;
  logic [17:0] ADDR0, ADDR1;
  logic [31:0] WDATA0, WDATA1;
  logic [3:0]  BE0, BE1;
  logic        ACK0, ACK1;
  logic [31:0] RDATA;
  logic [18:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_O, SRAM_DQ_I;
  logic        SRAM_DQ_OE, SRAM_nCE, SRAM_nWE, SRAM_nOE, SRAM_nLB, SRAM_nUB;

  // Latency-only instances for the WAIT_CYC extremes (index 0: WAIT_CYC=0, index 1: 15).
  logic [1:0]  l_req0, l_ack0, l_ack1, l_oe, l_nce, l_nwe, l_noe, l_nlb, l_nub;
  logic [31:0] l_rdata [2];
  logic [18:0] l_addr  [2];
  logic [15:0] l_dqo   [2];

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  always #5 HCLK = ~HCLK;

  sram_dual_port_sched #(.WAIT_CYC(1), .AW(19)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .BE0(BE0), .BE1(BE1), .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_DQ_I(SRAM_DQ_I), .SRAM_nCE(SRAM_nCE), .SRAM_nWE(SRAM_nWE),
    .SRAM_nOE(SRAM_nOE), .SRAM_nLB(SRAM_nLB), .SRAM_nUB(SRAM_nUB)
  );

  sram_dual_port_sched #(.WAIT_CYC(0), .AW(19)) u_w0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ0(l_req0[0]), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
    .ADDR0(18'h0), .ADDR1(18'h0), .WDATA0(32'h0), .WDATA1(32'h0),
    .BE0(4'h0), .BE1(4'h0), .ACK0(l_ack0[0]), .ACK1(l_ack1[0]), .RDATA(l_rdata[0]),
    .SRAM_ADDR(l_addr[0]), .SRAM_DQ_O(l_dqo[0]), .SRAM_DQ_OE(l_oe[0]),
    .SRAM_DQ_I(16'h0), .SRAM_nCE(l_nce[0]), .SRAM_nWE(l_nwe[0]),
    .SRAM_nOE(l_noe[0]), .SRAM_nLB(l_nlb[0]), .SRAM_nUB(l_nub[0])
  );

  sram_dual_port_sched #(.WAIT_CYC(15), .AW(19)) u_w15 (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ0(l_req0[1]), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
    .ADDR0(18'h0), .ADDR1(18'h0), .WDATA0(32'h0), .WDATA1(32'h0),
    .BE0(4'h0), .BE1(4'h0), .ACK0(l_ack0[1]), .ACK1(l_ack1[1]), .RDATA(l_rdata[1]),
    .SRAM_ADDR(l_addr[1]), .SRAM_DQ_O(l_dqo[1]), .SRAM_DQ_OE(l_oe[1]),
    .SRAM_DQ_I(16'h0), .SRAM_nCE(l_nce[1]), .SRAM_nWE(l_nwe[1]),
    .SRAM_nOE(l_noe[1]), .SRAM_nLB(l_nlb[1]), .SRAM_nUB(l_nub[1])
  );

  // SRAM pin model (halfword array) and word-level reference memory.
  bit [15:0] sram [int];
  bit [31:0] ref_mem [int];

  function automatic bit [15:0] sram_rd(input int a);
    return sram.exists(a) ? sram[a] : 16'h0;
  endfunction

  function automatic bit [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic void ref_wr(input int a, input bit [31:0] d, input bit [3:0] be);
    bit [31:0] w;
    w = ref_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endfunction

  always @(negedge HCLK) begin
    SRAM_DQ_I <= (!SRAM_nCE && !SRAM_nOE) ? sram_rd(int'(SRAM_ADDR)) : 16'hxxxx;
    if (!SRAM_nCE && !SRAM_nWE) begin
      bit [15:0] h;
      h = sram_rd(int'(SRAM_ADDR));
      if (!SRAM_nLB) h[7:0]  = SRAM_DQ_O[7:0];
      if (!SRAM_nUB) h[15:8] = SRAM_DQ_O[15:8];
      sram[int'(SRAM_ADDR)] = h;
    end
    if (ACK0 && ACK1) overlap++;
  end

  typedef struct packed {
    logic [18:0] a;
    logic [15:0] d;
    logic        nub;
    logic        nlb;
  } wmon_t;
  wmon_t wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns one cycle after ACK with the DUT idle again.
  task automatic xfer(input int port, input bit we, input logic [17:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output int lat, output int nwe_lo, output int noe_lo,
                      output int oe_hi, output int stray);
    lat = -1; nwe_lo = 0; noe_lo = 0; oe_hi = 0; stray = 0;
    wq.delete();
    if (port == 0) begin
      WE0 = we; ADDR0 = addr; WDATA0 = wd; BE0 = be; REQ0 = 1'b1;
    end else begin
      WE1 = we; ADDR1 = addr; WDATA1 = wd; BE1 = be; REQ1 = 1'b1;
    end
    for (int c = 1; c <= 60; c++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      if (!SRAM_nWE) begin
        nwe_lo++;
        wq.push_back('{a: SRAM_ADDR, d: SRAM_DQ_O, nub: SRAM_nUB, nlb: SRAM_nLB});
      end
      if (!SRAM_nOE) noe_lo++;
      if (SRAM_DQ_OE) oe_hi++;
      if ((port == 0 && ACK1) || (port == 1 && ACK0)) stray++;
      if ((port == 0 && ACK0) || (port == 1 && ACK1)) begin
        lat = c;
        break;
      end
    end
    if (we) ref_wr(int'(addr), wd, be);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  initial begin
    int lat, nwe, noe, oeh, stray;
    int n;
    int ack_cyc [4];
    logic [3:0] ack_port;
    logic [31:0] last_rd;
    int lat_w [2];
    bit rnd_we;
    int rnd_port;
    logic [17:0] rnd_addr;
    logic [31:0] rnd_wd;
    logic [3:0] rnd_be;
    bit seen_ack;

    HRESET = 1'b1;
    REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; ADDR0 = '0; ADDR1 = '0;
    WDATA0 = '0; WDATA1 = '0; BE0 = '0; BE1 = '0; l_req0 = 2'b00;
    repeat (3) @(negedge HCLK);

    chk("rst_strobes", {26'h0, SRAM_nCE, SRAM_nWE, SRAM_nOE, SRAM_nLB, SRAM_nUB, SRAM_DQ_OE}, 32'h3E);
    chk("rst_ack", {30'h0, ACK1, ACK0}, 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_addr_dq", {SRAM_ADDR, SRAM_DQ_O}, 35'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Port 0 full write
    xfer(0, 1'b1, 18'h00010, 32'hA5A55A5A, 4'hF, lat, nwe, noe, oeh, stray);
    chk("wr_lat", lat, 9);
    chk("wr_nwe_cycles", nwe, 4);
    chk("wr_noe_cycles", noe, 0);
    chk("wr_oe_cycles", oeh, 8);
    chk("wr_q_size", wq.size(), 4);
    if (wq.size() == 4) begin
      chk("wr_ph0", {wq[0].a, wq[0].d, wq[1].a, wq[1].d}, {19'h00020, 16'h5A5A, 19'h00020, 16'h5A5A});
      chk("wr_ph1", {wq[2].a, wq[2].d, wq[3].a, wq[3].d}, {19'h00021, 16'hA5A5, 19'h00021, 16'hA5A5});
    end

    // Port 1 read back
    xfer(1, 1'b0, 18'h00010, 32'h0, 4'h0, lat, nwe, noe, oeh, stray);
    chk("rd_lat", lat, 9);
    chk("rd_noe_cycles", noe, 4);
    chk("rd_oe_cycles", oeh, 0);
    chk("rd_stray_ack", stray, 0);
    chk("rd_data", RDATA, ref_rd(18'h00010));
    last_rd = RDATA;

    // Both requesters held: alternating grants, 10 cycles apart
    WE0 = 0; ADDR0 = 18'h00010; WE1 = 0; ADDR1 = 18'h00010;
    REQ0 = 1; REQ1 = 1;
    n = 0; ack_port = '0;
    for (int i = 0; i < 4; i++) ack_cyc[i] = -1;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      if (ACK0 || ACK1) begin
        ack_port[n] = ACK1;
        ack_cyc[n] = c;
        n++;
      end
    end
    REQ0 = 0; REQ1 = 0;
    @(posedge HCLK);
    @(negedge HCLK);
    chk("rr_count", n, 4);
    chk("rr_order", {28'h0, ack_port}, 32'hA);
    chk("rr_cycles", {ack_cyc[0][7:0], ack_cyc[1][7:0], ack_cyc[2][7:0], ack_cyc[3][7:0]},
        {8'd9, 8'd19, 8'd29, 8'd39});

    // Byte-enable write touching only byte 2
    xfer(0, 1'b1, 18'h00123, 32'hDEADBEEF, 4'hF, lat, nwe, noe, oeh, stray);
    xfer(1, 1'b1, 18'h00123, 32'h11223344, 4'h4, lat, nwe, noe, oeh, stray);
    chk("be4_lat", lat, 9);
    chk("be4_q_size", wq.size(), 4);
    if (wq.size() == 4) begin
      chk("be4_ph0_lanes", {30'h0, wq[0].nub, wq[0].nlb}, 32'h3);
      chk("be4_ph1", {wq[2].a, wq[2].d, wq[2].nub, wq[2].nlb}, {19'h00247, 16'h1122, 1'b1, 1'b0});
    end
    chk("rdata_hold_wr", RDATA, last_rd);
    xfer(0, 1'b0, 18'h00123, 32'h0, 4'h0, lat, nwe, noe, oeh, stray);
    chk("be4_readback", RDATA, 32'hDE22BEEF);
    last_rd = RDATA;

    // Randomized traffic over a small address window
    for (int t = 0; t < 30; t++) begin
      rnd_port = $urandom_range(0, 1);
      rnd_we   = 1'($urandom_range(0, 1));
      rnd_addr = 18'h00100 + 18'($urandom_range(0, 7));
      rnd_wd   = $urandom;
      rnd_be   = 4'($urandom_range(0, 15));
      xfer(rnd_port, rnd_we, rnd_addr, rnd_wd, rnd_be, lat, nwe, noe, oeh, stray);
      chk("rand_lat", lat, 9);
      chk("rand_stray", stray, 0);
      if (rnd_we) begin
        chk("rand_hold", RDATA, last_rd);
      end else begin
        chk("rand_rd", RDATA, ref_rd(int'(rnd_addr)));
        last_rd = RDATA;
      end
    end

    // Reset during phase-1 strobe
    WE1 = 0; ADDR1 = 18'h00010; REQ1 = 1;
    repeat (6) @(posedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    chk("mid_rst_strobes", {26'h0, SRAM_nCE, SRAM_nWE, SRAM_nOE, SRAM_nLB, SRAM_nUB, SRAM_DQ_OE}, 32'h3E);
    chk("mid_rst_rdata", RDATA, 32'h0);
    @(negedge HCLK);
    REQ1 = 0;
    @(negedge HCLK);
    HRESET = 1'b0;
    seen_ack = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge HCLK);
      if (ACK0 || ACK1) seen_ack = 1'b1;
    end
    chk("mid_rst_no_ack", {31'h0, seen_ack}, 32'h0);
    xfer(1, 1'b0, 18'h00010, 32'h0, 4'h0, lat, nwe, noe, oeh, stray);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_rd", RDATA, ref_rd(18'h00010));

    // WAIT_CYC extremes
    lat_w[0] = -1; lat_w[1] = -1;
    l_req0 = 2'b11;
    for (int c = 1; c <= 50; c++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      for (int k = 0; k < 2; k++) begin
        if (l_ack0[k] && lat_w[k] < 0) begin
          lat_w[k] = c;
          l_req0[k] = 1'b0;
        end
      end
    end
    l_req0 = 2'b00;
    chk("lat_wait0", lat_w[0], 7);
    chk("lat_wait15", lat_w[1], 37);

    chk("ack_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
